lsu: RTL and testbench
======================

# lsu

Load/store unit: the initiator on the data port of the 16 KiB `ram`. It accepts one load or store request at a time from the execute stage over a valid/ready handshake and drives `ram`'s data-side controls for exactly one access. It captures the registered load data one cycle later and returns a response (data, destination register, fault flag) over a second valid/ready handshake. Alignment and range checks happen before any memory traffic.

## Interface
- No parameters; widths fixed: 32-bit data/address, 14-bit RAM byte address, 5-bit register index.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  LSU can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_unsigned`  in  1  zero-extend loads (LBU/LHU).
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `req_rd`  in  5  destination register, echoed on the response.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer takes the response.
- `resp_rdata`  out  32  load result; 0 for stores and faults.
- `resp_rd`  out  5  echoed `req_rd`.
- `resp_fault`  out  1  access rejected; RAM untouched.
- `ram_w_en`, `ram_u_en`  out  1  to `ram.w_en`, `ram.u_en`.
- `ram_d_addr`  out  14  to `ram.d_addr`.
- `ram_d_in`  out  32  to `ram.d_in`.
- `ram_d_size`  out  2  to `ram.d_size`.
- `ram_d_out`  in  32  from `ram.d_out`, registered one cycle after the address.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`: latch all request fields and evaluate the fault check.
  - Fault → RESP with `resp_fault`=1 and `resp_rdata`=0; otherwise → ISSUE.
- ISSUE:
  - `ram_d_addr`=`req_addr[13:0]`, `ram_d_size`=size, `ram_u_en`=unsigned, `ram_d_in`=wdata.
  - `ram_w_en`=we for this cycle only.
  - Store → RESP. Load → CAPTURE.
- CAPTURE: `ram_w_en`=0, address held; at the edge, `resp_rdata` ← `ram_d_out`; → RESP.
- RESP:
  - `resp_valid`=1; `resp_rdata`, `resp_rd` and `resp_fault` held stable.
  - On `resp_ready` → IDLE.
- Fault conditions:
  - Always: size 11; `req_addr[31:14]` ≠ 0.
  - With the macro enabled, also: half with `addr[0]`=1; word with `addr[1:0]`≠0.
- `ram_w_en` is 0 in every state except ISSUE with a store latched.
- Between accesses, the `ram_*` outputs hold their last values, except `ram_w_en`.

## Timing
- Reset values:
  - state IDLE;
  - `resp_valid`, `resp_fault`, `ram_w_en`, `ram_u_en` = 0;
  - `resp_rdata`, `resp_rd`, `ram_d_addr`, `ram_d_in`, `ram_d_size` = 0.
- `req_ready` is forced 0 while `reset` is low.
- Accept occurs at edge E0 (`req_valid` && `req_ready`). `resp_valid` first goes high:
  - store: cycle after E1 (2-cycle latency);
  - load: cycle after E2 (3-cycle latency);
  - fault: cycle after E0 (1-cycle latency).
- Throughput: `req_ready` returns the cycle after the RESP handshake. There is no same-cycle accept during RESP.
- `req_valid` outside IDLE is ignored; requests are not queued.
- `resp_ready` held low: stay in RESP indefinitely with outputs stable.
- Reset asserted mid-operation:
  - asynchronously return to IDLE and drop `ram_w_en`;
  - a store in ISSUE whose edge falls within reset is not written;
  - a pending response is discarded.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - misaligned half/word accesses fault (`resp_fault`=1);
  - RAM is never accessed for them.
- Undefined:
  - no misalignment fault; the address is aligned down before issue (half clears bit 0, word clears bits 1:0);
  - size-11 and out-of-range faults are unaffected.

## Structure
- Shared package `riscy_pkg` holds:
  - size encodings BYTE=00, HALF=01, WORD=10;
  - the LSU state enum;
  - `RAM_ADDR_W`=14.
- One sub-module, `lsu_addr_chk`: purely combinational. Takes size and address; outputs fault and the aligned 14-bit address. It is the only place `LSU_MISALIGN_TRAP_EN` is tested.

## Test plan
- RAM zeroed. SW 0x10 ← 0xDEADBEEF, rd=0 → `resp_valid` in cycle 2, fault 0. Then LW 0x10, rd=5 → `resp_rdata`=0xDEADBEEF and `resp_rd`=5 in cycle 3.
- After the above:
  - LB 0x13 → 0xFFFFFFDE; LBU 0x13 → 0x000000DE;
  - LH 0x12 → 0xFFFFDEAD; LHU 0x10 → 0x0000BEEF.
- LW 0x12:
  - with macro → `resp_fault`=1 in cycle 1, `ram_w_en` never high;
  - without macro → returns the word at 0x10 (0xDEADBEEF).
- SB 0x4000 or size=11 → fault in cycle 1; memory unchanged on readback.
- `resp_ready` low for 5 cycles during a load response, with `req_valid` held high:
  - `resp_rdata` stable, `req_ready`=0, second request not accepted;
  - second request accepted the cycle after handshake.
- SW 0x20 ← 0x12345678 with `reset` pulled low during ISSUE → all outputs return to reset values; LW 0x20 after reset reads 0.

Source files
------------

// File: rtl/riscy_pkg.sv
// riscy_pkg
// Shared definitions for the riscy core slice: access-size encodings, the
// load/store unit state encoding and the RAM byte-address width.
// Ports: none (package).
package riscy_pkg;

  localparam int RAM_ADDR_W = 14;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    LSU_IDLE    = 2'd0,
    LSU_ISSUE   = 2'd1,
    LSU_CAPTURE = 2'd2,
    LSU_RESP    = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/lsu_addr_chk.sv
// lsu_addr_chk
// Purely combinational legality check for one load/store request, plus the
// RAM address that will actually be issued.
// Configuration macro: LSU_MISALIGN_TRAP_EN
//   defined   - misaligned half/word accesses are reported as faults
//   undefined - misaligned accesses are aligned down silently
// Ports:
//   size         in  2   access size (00 byte, 01 half, 10 word, 11 illegal)
//   addr         in  32  byte address from the request
//   fault        out 1   request must be rejected without touching RAM
//   aligned_addr out 14  RAM byte address to issue
module lsu_addr_chk
  import riscy_pkg::*;
(
  input  logic [1:0]            size,
  input  logic [31:0]           addr,
  output logic                  fault,
  output logic [RAM_ADDR_W-1:0] aligned_addr
);

`ifdef LSU_MISALIGN_TRAP_EN
  // Misaligned accesses trap, so the address never needs adjusting.
  logic misalign;

  always_comb begin
    misalign = ((size == SIZE_HALF) && addr[0]) ||
               ((size == SIZE_WORD) && (addr[1:0] != 2'b00));
    fault        = (size == 2'b11) || (|addr[31:RAM_ADDR_W]) || misalign;
    aligned_addr = addr[RAM_ADDR_W-1:0];
  end
`else
  // Without the trap, half accesses drop bit 0 and word accesses drop bits 1:0.
  always_comb begin
    fault        = (size == 2'b11) || (|addr[31:RAM_ADDR_W]);
    aligned_addr = addr[RAM_ADDR_W-1:0];
    if (size == SIZE_HALF) begin
      aligned_addr[0] = 1'b0;
    end else if (size == SIZE_WORD) begin
      aligned_addr[1:0] = 2'b00;
    end
  end
`endif

endmodule

// File: rtl/lsu.sv
// lsu
// Load/store unit: accepts one request at a time from execute, performs a
// single access on the data port of the 16 KiB ram and returns a response.
// Configuration macro: LSU_MISALIGN_TRAP_EN (tested only in lsu_addr_chk).
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready handshake; req_we, req_unsigned, req_size,
//   req_addr, req_wdata, req_rd request fields
//   resp_valid/resp_ready handshake; resp_rdata, resp_rd, resp_fault
//   ram_w_en, ram_u_en, ram_d_addr, ram_d_in, ram_d_size to the ram
//   ram_d_out from the ram, registered one cycle after the address
module lsu
  import riscy_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic                  req_unsigned,
  input  logic [1:0]            req_size,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [4:0]            req_rd,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic [4:0]            resp_rd,
  output logic                  resp_fault,
  output logic                  ram_w_en,
  output logic                  ram_u_en,
  output logic [RAM_ADDR_W-1:0] ram_d_addr,
  output logic [31:0]           ram_d_in,
  output logic [1:0]            ram_d_size,
  input  logic [31:0]           ram_d_out
);

  lsu_state_t            state;
  logic                  we_q;
  logic                  chk_fault;
  logic [RAM_ADDR_W-1:0] chk_addr;

  lsu_addr_chk u_addr_chk (
    .size         (req_size),
    .addr         (req_addr),
    .fault        (chk_fault),
    .aligned_addr (chk_addr)
  );

  // req_ready also looks at reset so nothing is offered while held in reset.
  // ram_w_en is a pure state decode, so an async reset drops it immediately
  // and a store whose issue edge lands inside reset is never written.
  assign req_ready  = (state == LSU_IDLE) && reset;
  assign resp_valid = (state == LSU_RESP);
  assign ram_w_en   = (state == LSU_ISSUE) && we_q;

  // Faulting requests skip the ram_* registers entirely, so the RAM port
  // keeps its previous address/data and is never exercised for them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= LSU_IDLE;
      we_q       <= 1'b0;
      resp_rdata <= 32'd0;
      resp_rd    <= 5'd0;
      resp_fault <= 1'b0;
      ram_u_en   <= 1'b0;
      ram_d_addr <= '0;
      ram_d_in   <= 32'd0;
      ram_d_size <= 2'b00;
    end else begin
      case (state)
        LSU_IDLE: begin
          if (req_valid) begin
            we_q       <= req_we;
            resp_rd    <= req_rd;
            resp_rdata <= 32'd0;
            resp_fault <= chk_fault;
            if (chk_fault) begin
              state <= LSU_RESP;
            end else begin
              ram_d_addr <= chk_addr;
              ram_d_size <= req_size;
              ram_u_en   <= req_unsigned;
              ram_d_in   <= req_wdata;
              state      <= LSU_ISSUE;
            end
          end
        end
        LSU_ISSUE: begin
          state <= we_q ? LSU_RESP : LSU_CAPTURE;
        end
        LSU_CAPTURE: begin
          resp_rdata <= ram_d_out;
          state      <= LSU_RESP;
        end
        LSU_RESP: begin
          if (resp_ready) begin
            state <= LSU_IDLE;
          end
        end
        default: begin
          state <= LSU_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu
// Bench for lsu: a byte-array model of the ram data port, a directed request
// driver that queues hand-computed expected responses, and a monitor that
// pops and compares every response handshake.
module tb_lsu;
  import riscy_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        resp_fault;
  logic        ram_w_en;
  logic        ram_u_en;
  logic [13:0] ram_d_addr;
  logic [31:0] ram_d_in;
  logic [1:0]  ram_d_size;
  logic [31:0] ram_d_out;

  typedef struct packed {
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        fault;
  } resp_t;

  resp_t sb_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    w_en_count = 0;

  lsu dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_unsigned (req_unsigned),
    .req_size     (req_size),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_rd       (req_rd),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_rd      (resp_rd),
    .resp_fault   (resp_fault),
    .ram_w_en     (ram_w_en),
    .ram_u_en     (ram_u_en),
    .ram_d_addr   (ram_d_addr),
    .ram_d_in     (ram_d_in),
    .ram_d_size   (ram_d_size),
    .ram_d_out    (ram_d_out)
  );

  always #5 clk = ~clk;

  // Little-endian ram model: writes on the edge, read data registered with
  // sign/zero extension chosen by u_en.
  logic [7:0]  mem [0:16383] = '{default: 8'h00};
  logic [13:0] a1, a2, a3;
  logic [31:0] rd_word;

  assign a1 = ram_d_addr + 14'd1;
  assign a2 = ram_d_addr + 14'd2;
  assign a3 = ram_d_addr + 14'd3;
  assign rd_word = {mem[a3], mem[a2], mem[a1], mem[ram_d_addr]};

  always @(posedge clk) begin
    if (ram_w_en) begin
      mem[ram_d_addr] <= ram_d_in[7:0];
      if (ram_d_size != SIZE_BYTE) mem[a1] <= ram_d_in[15:8];
      if (ram_d_size == SIZE_WORD) begin
        mem[a2] <= ram_d_in[23:16];
        mem[a3] <= ram_d_in[31:24];
      end
    end
    case (ram_d_size)
      SIZE_BYTE: ram_d_out <= ram_u_en ? {24'd0, rd_word[7:0]}
                                       : {{24{rd_word[7]}}, rd_word[7:0]};
      SIZE_HALF: ram_d_out <= ram_u_en ? {16'd0, rd_word[15:0]}
                                       : {{16{rd_word[15]}}, rd_word[15:0]};
      default:   ram_d_out <= rd_word;
    endcase
  end

  always @(posedge clk) begin
    if (ram_w_en) w_en_count <= w_en_count + 1;
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Issues one request, queues its expected response and checks the
  // accept-to-valid latency (edges counted including the accept edge).
  task automatic apply_stimulus(input string name, input logic we, input logic uns,
                                input logic [1:0] size, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [4:0] rd,
                                input logic [31:0] exp_rdata, input logic exp_fault,
                                input int exp_lat);
    int lat;
    int waits;
    resp_t e;
    @(negedge clk);
    req_we = we; req_unsigned = uns; req_size = size;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    req_valid = 1'b1;
    waits = 0;
    while (!req_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (!req_ready) begin
      check_output({name, "_accept"}, 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    e.rdata = exp_rdata; e.rd = rd; e.fault = exp_fault;
    sb_q.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_output({name, "_lat"}, lat, exp_lat);
    waits = 0;
    while (resp_valid && waits < 20) begin
      @(posedge clk);
      #1;
      waits++;
    end
    check_output({name, "_done"}, {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int snap;
    int waits;
    resp_t e;

    reset = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
    req_we = 1'b0; req_unsigned = 1'b0; req_size = 2'b00;
    req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;

    // Monitor: every response handshake is compared against the queue head.
    fork
      forever begin
        @(negedge clk);
        if (reset && resp_valid && resp_ready) begin
          if (sb_q.size() == 0) begin
            check_output("unexpected_resp", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            check_output("resp_rdata", resp_rdata, e.rdata);
            check_output("resp_rd", {27'd0, resp_rd}, {27'd0, e.rd});
            check_output("resp_fault", {31'd0, resp_fault}, {31'd0, e.fault});
          end
        end
      end
    join_none

    #12;
    check_output("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check_output("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check_output("rst_w_en", {31'd0, ram_w_en}, 32'd0);
    check_output("rst_d_addr", {18'd0, ram_d_addr}, 32'd0);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    check_output("idle_req_ready", {31'd0, req_ready}, 32'd1);

    apply_stimulus("sw_10", 1'b1, 1'b0, SIZE_WORD, 32'h10, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 2);
    apply_stimulus("lw_10", 1'b0, 1'b0, SIZE_WORD, 32'h10, 32'h0, 5'd5, 32'hDEADBEEF, 1'b0, 3);
    apply_stimulus("lb_13", 1'b0, 1'b0, SIZE_BYTE, 32'h13, 32'h0, 5'd1, 32'hFFFFFFDE, 1'b0, 3);
    apply_stimulus("lbu_13", 1'b0, 1'b1, SIZE_BYTE, 32'h13, 32'h0, 5'd2, 32'h000000DE, 1'b0, 3);
    apply_stimulus("lh_12", 1'b0, 1'b0, SIZE_HALF, 32'h12, 32'h0, 5'd3, 32'hFFFFDEAD, 1'b0, 3);
    apply_stimulus("lhu_10", 1'b0, 1'b1, SIZE_HALF, 32'h10, 32'h0, 5'd4, 32'h0000BEEF, 1'b0, 3);

    snap = w_en_count;
`ifdef LSU_MISALIGN_TRAP_EN
    apply_stimulus("lw_12", 1'b0, 1'b0, SIZE_WORD, 32'h12, 32'h0, 5'd6, 32'h0, 1'b1, 1);
`else
    apply_stimulus("lw_12", 1'b0, 1'b0, SIZE_WORD, 32'h12, 32'h0, 5'd6, 32'hDEADBEEF, 1'b0, 3);
`endif
    check_output("lw_12_no_write", w_en_count - snap, 32'd0);

    snap = w_en_count;
    apply_stimulus("sb_4000", 1'b1, 1'b0, SIZE_BYTE, 32'h4000, 32'hAA, 5'd7, 32'h0, 1'b1, 1);
    apply_stimulus("sz11_st", 1'b1, 1'b0, 2'b11, 32'h10, 32'h11111111, 5'd8, 32'h0, 1'b1, 1);
    check_output("fault_no_write", w_en_count - snap, 32'd0);
    apply_stimulus("lw_0", 1'b0, 1'b0, SIZE_WORD, 32'h0, 32'h0, 5'd9, 32'h0, 1'b0, 3);
    apply_stimulus("lw_10_rb", 1'b0, 1'b0, SIZE_WORD, 32'h10, 32'h0, 5'd9, 32'hDEADBEEF, 1'b0, 3);

    // Back-pressure: first load stalls in RESP while a second request waits.
    @(negedge clk);
    resp_ready = 1'b0;
    req_we = 1'b0; req_unsigned = 1'b0; req_size = SIZE_WORD;
    req_addr = 32'h10; req_wdata = 32'h0; req_rd = 5'd10; req_valid = 1'b1;
    check_output("bp_idle_ready", {31'd0, req_ready}, 32'd1);
    e.rdata = 32'hDEADBEEF; e.rd = 5'd10; e.fault = 1'b0;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    req_unsigned = 1'b1; req_size = SIZE_BYTE; req_addr = 32'h13; req_rd = 5'd11;
    waits = 0;
    while (!resp_valid && waits < 10) begin
      @(posedge clk);
      #1;
      waits++;
    end
    check_output("bp_lat", waits + 1, 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("bp_rdata", resp_rdata, 32'hDEADBEEF);
      check_output("bp_req_ready", {31'd0, req_ready}, 32'd0);
      check_output("bp_d_addr", {18'd0, ram_d_addr}, 32'h10);
    end
    e.rdata = 32'h000000DE; e.rd = 5'd11; e.fault = 1'b0;
    sb_q.push_back(e);
    @(posedge clk);
    #1 resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check_output("bp_ready_after", {31'd0, req_ready}, 32'd1);
    check_output("bp_valid_after", {31'd0, resp_valid}, 32'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    waits = 0;
    while (!resp_valid && waits < 10) begin
      @(posedge clk);
      #1;
      waits++;
    end
    check_output("bp2_lat", waits + 1, 32'd3);
    waits = 0;
    while (resp_valid && waits < 10) begin
      @(posedge clk);
      #1;
      waits++;
    end

    apply_stimulus("sb_11", 1'b1, 1'b0, SIZE_BYTE, 32'h11, 32'h1234565A, 5'd0, 32'h0, 1'b0, 2);
    apply_stimulus("lw_10_sb", 1'b0, 1'b0, SIZE_WORD, 32'h10, 32'h0, 5'd12, 32'hDEAD5AEF, 1'b0, 3);

    // Reset pulled low while a store sits in ISSUE.
    @(negedge clk);
    req_we = 1'b1; req_unsigned = 1'b0; req_size = SIZE_WORD;
    req_addr = 32'h20; req_wdata = 32'h12345678; req_rd = 5'd13; req_valid = 1'b1;
    check_output("rst_st_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    check_output("rst_st_w_en", {31'd0, ram_w_en}, 32'd1);
    check_output("rst_st_d_addr", {18'd0, ram_d_addr}, 32'h20);
    #2 reset = 1'b0;
    #1;
    check_output("mid_rst_w_en", {31'd0, ram_w_en}, 32'd0);
    check_output("mid_rst_req_ready", {31'd0, req_ready}, 32'd0);
    check_output("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check_output("mid_rst_d_addr", {18'd0, ram_d_addr}, 32'd0);
    check_output("mid_rst_d_in", ram_d_in, 32'd0);
    check_output("mid_rst_d_size", {30'd0, ram_d_size}, 32'd0);
    check_output("mid_rst_u_en", {31'd0, ram_u_en}, 32'd0);
    check_output("mid_rst_rdata", resp_rdata, 32'd0);
    check_output("mid_rst_rd", {27'd0, resp_rd}, 32'd0);
    check_output("mid_rst_fault", {31'd0, resp_fault}, 32'd0);
    @(posedge clk);
    @(negedge clk) reset = 1'b1;
    apply_stimulus("lw_20", 1'b0, 1'b0, SIZE_WORD, 32'h20, 32'h0, 5'd14, 32'h0, 1'b0, 3);

    repeat (3) @(negedge clk);
    check_output("sb_empty", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
